// File: rtl/instr_sequencer.sv
// Program sequencer: owns the PC, fetches 16-bit instructions over a
// req/ack handshake, resolves jumps and conditional squashing from the
// latched CMP flags, issues one instruction at a time to the decoder and
// stalls until the ALU or memory unit reports completion.
// Optional macro SEQ_TIMEOUT_EN bounds every wait with an 8-bit counter and
// halts with error=1 when TIMEOUT waiting cycles pass without ack/done.
module instr_sequencer #(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [15:0]       instr_data,
    output logic [15:0]       dec_instr,
    output logic              dec_valid,
    input  logic              alu_done,
    input  logic              mem_done,
    input  logic              zero_in,
    input  logic              gt_in,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] NOP_WORD = 16'h000D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISPATCH,
        S_WAIT_ALU,
        S_WAIT_MEM,
        S_HALT
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       ir_reg, ir_next;
    logic [15:0]       dec_hold_reg, dec_hold_next;
    logic              done_reg, done_next;
    logic              zf_reg, zf_next;
    logic              gf_reg, gf_next;
    logic              issue;
    logic [15:0]       issue_word;
    logic              timeout_hit;

    // Decode fields of the latched instruction
    logic [3:0]        op;
    logic [1:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              cond_true;
    logic              is_cond_op;

    assign op         = ir_reg[3:0];
    assign cond       = ir_reg[15:14];
    assign target     = ADDR_W'(ir_reg[13:4]);
    assign pc_inc     = pc_reg + ADDR_W'(1);
    assign is_cond_op = (op >= 4'd1) && (op <= 4'd8);

    // Condition evaluation from the persistent CMP flags
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            2'b00:   cond_true = zf_reg;
            2'b01:   cond_true = gf_reg;
            2'b10:   cond_true = 1'b1;
            default: cond_true = !zf_reg;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc_reg       <= '0;
            ir_reg       <= NOP_WORD;
            dec_hold_reg <= NOP_WORD;
            done_reg     <= 1'b0;
            zf_reg       <= 1'b0;
            gf_reg       <= 1'b0;
        end else begin
            state        <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            dec_hold_reg <= dec_hold_next;
            done_reg     <= done_next;
            zf_reg       <= zf_next;
            gf_reg       <= gf_next;
        end
    end

    // Next-state, datapath updates and issue decision
    always_comb begin
        state_next    = state;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        done_next     = done_reg;
        zf_next       = zf_reg;
        gf_next       = gf_reg;
        issue         = 1'b0;
        issue_word    = NOP_WORD;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_next    = START_ADDR;
                    done_next  = 1'b0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_ack) begin
                    ir_next    = instr_data;
                    state_next = S_DISPATCH;
                end else if (timeout_hit) begin
                    done_next  = 1'b0;
                    state_next = S_HALT;
                end
            end
            S_DISPATCH: begin
                if (op == 4'd1) begin
                    // Jumps are resolved here and never reach the decoder
                    pc_next    = cond_true ? target : pc_inc;
                    state_next = S_FETCH;
                end else if (is_cond_op && !cond_true) begin
                    // Squashed op: decoder sees a NOP, no completion to wait for
                    issue      = 1'b1;
                    pc_next    = pc_inc;
                    state_next = S_FETCH;
                end else begin
                    issue      = 1'b1;
                    issue_word = ir_reg;
                    case (op)
                        4'd14: begin
                            done_next  = 1'b1;
                            state_next = S_HALT;
                        end
                        4'd4, 4'd5: begin
                            pc_next    = pc_inc;
                            state_next = S_WAIT_MEM;
                        end
                        4'd8, 4'd13, 4'd15: begin
                            pc_next    = pc_inc;
                            state_next = S_FETCH;
                        end
                        default: begin
                            pc_next    = pc_inc;
                            state_next = S_WAIT_ALU;
                        end
                    endcase
                end
            end
            S_WAIT_ALU: begin
                if (alu_done) begin
                    state_next = S_FETCH;
                    if (op == 4'd0) begin
                        zf_next = zero_in;
                        gf_next = gt_in;
                    end
                end else if (timeout_hit) begin
                    done_next  = 1'b0;
                    state_next = S_HALT;
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    done_next  = 1'b0;
                    state_next = S_HALT;
                end
            end
            default: state_next = S_IDLE;
        endcase
        dec_hold_next = issue ? issue_word : dec_hold_reg;
    end

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic       error_reg;
    logic       waiting;
    logic       restart;

    assign waiting = ((state == S_FETCH)    && !instr_ack) ||
                     ((state == S_WAIT_ALU) && !alu_done)  ||
                     ((state == S_WAIT_MEM) && !mem_done);
    assign restart = ((state == S_IDLE) || (state == S_HALT)) && start;
    assign timeout_hit = waiting && (wait_cnt_reg == 8'(TIMEOUT - 1));

    // Wait counter restarts on every state change, counts cycles spent waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_next != state) begin
            wait_cnt_reg <= '0;
        end else if (waiting) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // Sticky timeout flag, cleared only by a new start or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_reg <= 1'b0;
        end else if (restart) begin
            error_reg <= 1'b0;
        end else if (timeout_hit) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign error          = 1'b0;
`endif

    assign instr_req  = (state == S_FETCH);
    assign instr_addr = pc_reg;
    assign pc         = pc_reg;
    assign dec_valid  = issue;
    assign dec_instr  = issue ? issue_word : dec_hold_reg;
    assign running    = (state != S_IDLE) && (state != S_HALT);
    assign done       = done_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by
// random instructions, checked against an instruction-level reference model.
module tb_instr_sequencer;

    localparam int          ADDR_W = 10;
    localparam logic [9:0]  START  = 10'd1023;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ack = 1'b0;
    logic [15:0]       instr_data = 16'h0000;
    logic [15:0]       dec_instr;
    logic              dec_valid;
    logic              alu_done = 1'b0;
    logic              mem_done = 1'b0;
    logic              zero_in = 1'b0;
    logic              gt_in = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              running;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    // Reference model state (architectural view only)
    int          m_pc = 0;
    bit          m_zf = 1'b0;
    bit          m_gf = 1'b0;
    logic [15:0] m_last = 16'h000D;
    bit          m_halt = 1'b0;

    instr_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr_req (instr_req),
        .instr_addr(instr_addr),
        .instr_ack (instr_ack),
        .instr_data(instr_data),
        .dec_instr (dec_instr),
        .dec_valid (dec_valid),
        .alu_done  (alu_done),
        .mem_done  (mem_done),
        .zero_in   (zero_in),
        .gt_in     (gt_in),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 39) == 0) w[3:0] = 4'hE;
        else if (w[3:0] == 4'hE) w[3:0] = 4'hD;
        return w;
    endfunction

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc   = int'(START);
        m_halt = 1'b0;
        check("restart_done", done, 0);
        check("restart_running", running, 1);
    endtask

    // Run one instruction through fetch, dispatch and optional wait
    task automatic exec(input logic [15:0] ins, input int ack_dly, input int wait_dly,
                        input bit z, input bit g);
        logic [3:0]  op;
        logic [1:0]  cnd;
        bit          ok, squash, issues, halt;
        int          kind;
        int          nxt_pc;
        int          n;
        logic [15:0] word;
        op     = ins[3:0];
        cnd    = ins[15:14];
        ok     = (cnd == 2'd0) ? m_zf : (cnd == 2'd1) ? m_gf : (cnd == 2'd2) ? 1'b1 : !m_zf;
        squash = (op >= 4'd1) && (op <= 4'd8) && !ok;
        issues = (op != 4'd1);
        word   = squash ? 16'h000D : ins;
        halt   = (op == 4'd14);
        kind   = 0;
        if (!squash && (op inside {4'd0, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12})) kind = 1;
        if (!squash && (op inside {4'd4, 4'd5})) kind = 2;
        if (op == 4'd1 && ok) nxt_pc = int'(ins[13:4]);
        else if (halt)        nxt_pc = m_pc;
        else                  nxt_pc = (m_pc + 1) % 1024;

        n = 0;
        while (instr_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("fetch_req", instr_req, 1);
        check("fetch_addr", instr_addr, m_pc);
        repeat (ack_dly) tick();
        instr_ack  = 1'b1;
        instr_data = ins;
        tick();
        instr_ack  = 1'b0;
        instr_data = 16'($urandom);
        check("dec_valid", dec_valid, issues);
        check("dec_instr", dec_instr, issues ? word : m_last);
        check("req_drop", instr_req, 0);
        if (issues) m_last = word;
        tick();
        check("no_reissue", dec_valid, 0);
        if (kind != 0) begin
            for (int i = 0; i < wait_dly; i++) begin
                if (kind == 1) mem_done = 1'($urandom);
                else           alu_done = 1'($urandom);
                zero_in   = 1'($urandom);
                gt_in     = 1'($urandom);
                instr_ack = 1'($urandom);
                tick();
                check("stall_req", instr_req, 0);
            end
            mem_done  = 1'b0;
            alu_done  = 1'b0;
            instr_ack = 1'b0;
            if (kind == 1) alu_done = 1'b1;
            else           mem_done = 1'b1;
            zero_in = z;
            gt_in   = g;
            tick();
            alu_done = 1'b0;
            mem_done = 1'b0;
            if (kind == 1 && op == 4'd0) begin
                m_zf = z;
                m_gf = g;
            end
        end
        m_pc   = nxt_pc;
        m_halt = halt;
        check("pc", pc, m_pc);
        check("running", running, !halt);
        check("done", done, halt);
        $display("instr ins=%04h issued=%0d word=%04h wait=%0d pc=%03h zf=%0d gf=%0d",
                 ins, issues, word, kind, m_pc, m_zf, m_gf);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_req"}, instr_req, 0);
        check({tag, "_addr"}, instr_addr, 0);
        check({tag, "_dec_instr"}, dec_instr, 16'h000D);
        check({tag, "_dec_valid"}, dec_valid, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        int n;
        // Reset values
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_running", running, 0);
        restart();

        // Directed: wrap, CMP, jumps, squash, memory stall, END, restart
        exec(16'h000D, 0, 0, 1'b0, 1'b0);
        exec(16'h08C0, 2, 3, 1'b1, 1'b0);
        exec(16'h0201, 1, 0, 1'b0, 1'b0);
        exec(16'h08C0, 0, 1, 1'b0, 1'b0);
        exec(16'h0201, 0, 0, 1'b0, 1'b0);
        exec(16'h4002, 0, 0, 1'b0, 1'b0);
        exec(16'h08C0, 0, 2, 1'b1, 1'b0);
        exec(16'h2B05, 0, 6, 1'b0, 1'b0);
        exec(16'h000E, 1, 0, 1'b0, 1'b0);
        tick();
        check("halt_hold_done", done, 1);
        restart();
        exec(16'h000D, 0, 0, 1'b0, 1'b0);

        // Random instruction stream
        for (int k = 0; k < 150; k++) begin
            exec(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4),
                 1'($urandom), 1'($urandom));
            if (m_halt) restart();
        end

        // Asynchronous reset while waiting on memory
        n = 0;
        while (instr_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("pre_abort_req", instr_req, 1);
        instr_ack  = 1'b1;
        instr_data = 16'h8004;
        tick();
        instr_ack  = 1'b0;
        tick();
        check("wait_mem_req", instr_req, 0);
        check("wait_mem_running", running, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        rst_n  = 1'b1;
        m_zf   = 1'b0;
        m_gf   = 1'b0;
        m_last = 16'h000D;
        tick();
        restart();

`ifdef SEQ_TIMEOUT_EN
        // Withheld ack: four waiting cycles then HALT with error
        n = 0;
        while (instr_req === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 4);
        check("timeout_error", error, 1);
        check("timeout_done", done, 0);
        check("timeout_running", running, 0);
        restart();
        check("timeout_error_clr", error, 0);
`else
        // Withheld ack: fetch waits indefinitely, no error
        repeat (300) tick();
        check("unbounded_req", instr_req, 1);
        check("unbounded_error", error, 0);
        check("unbounded_running", running, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
